// File: rtl/run_controller.sv
// run_controller: run-control sequencer for the 8-bit core plus the DataRAM port arbiter.
// It holds the fetch unit at the program start address, launches on host Go, counts RUN
// cycles, and stops on Halt or after MAX_CYCLES. The host owns the DataRAM port while the
// core is stopped, and the core owns it while the core runs.
//
// Host handshake: Host_Req is a level request, and Host_Gnt is its completion strobe.
// An access is performed in exactly the cycle where Host_Req && Host_Gnt hold.
// A write commits at that cycle's posedge. Read data on Host_RData is valid only
// while Host_Gnt is high. When Host_Gnt is low, the host must hold its request
// unchanged and no write takes place. This is the case in LAUNCH, in RUN and during reset.
module run_controller #(
  parameter int          ADDR_W     = 8,
  parameter int          DATA_W     = 8,
  parameter int          CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFFF
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Go,
  input  logic [ADDR_W-1:0] Prog_Addr,
  input  logic              Halt,
  output logic              Start,
  output logic [ADDR_W-1:0] Start_Addr,
  output logic              Running,
  output logic              Done,
  output logic              Timeout,
  output logic [CNT_W-1:0]  InstrCount,
  output logic [1:0]        State_Dbg,
  input  logic              Host_Req,
  input  logic              Host_WE,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [DATA_W-1:0] Host_WData,
  output logic              Host_Gnt,
  output logic [DATA_W-1:0] Host_RData,
  input  logic              Core_MemRead,
  input  logic              Core_MemWrite,
  input  logic [ADDR_W-1:0] Core_Addr,
  input  logic [DATA_W-1:0] Core_WData,
  output logic [DATA_W-1:0] Core_RData,
  output logic              Mem_RE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST_RUN = CNT_W'(MAX_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                timeout_q, timeout_d;
  logic                host_gnt;

  // State and run bookkeeping registers, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      start_addr_q <= '0;
      count_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic: launch when the host is not using memory, then count RUN cycles until Halt or timeout.
  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    count_d      = count_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Go && !Host_Req) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        start_addr_d = Prog_Addr;
        count_d      = '0;
        timeout_d    = 1'b0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        // Saturate rather than wrap. The timeout stop normally keeps the count from reaching this point.
        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        if (Halt) begin
          state_d = ST_DONE;
        end else if (count_q == CNT_LAST_RUN) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!Go) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    Start      = (state_q != ST_RUN);
    Running    = (state_q == ST_RUN);
    Done       = (state_q == ST_DONE);
    Timeout    = timeout_q && (state_q == ST_DONE);
    Start_Addr = start_addr_q;
    InstrCount = count_q;
    State_Dbg  = state_q;
  end

  // DataRAM port mux. The core owns the port only in RUN; the host is granted only in IDLE or DONE.
  always_comb begin
    host_gnt   = Reset_n && Host_Req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    Host_Gnt   = host_gnt;
    Host_RData = Mem_RData;
    Core_RData = Mem_RData;
    if (state_q == ST_RUN) begin
      Mem_RE    = Reset_n && Core_MemRead;
      Mem_WE    = Reset_n && Core_MemWrite;
      Mem_Addr  = Core_Addr;
      Mem_WData = Core_WData;
    end else begin
      Mem_RE    = host_gnt && !Host_WE;
      Mem_WE    = host_gnt && Host_WE;
      Mem_Addr  = Host_Addr;
      Mem_WData = Host_WData;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed run-control and arbitration sequence with a DataRAM model.
`timescale 1ns/1ps
module tb_run_controller;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;

  logic              CLK = 1'b0;
  logic              Reset_n, Go, Halt;
  logic [ADDR_W-1:0] Prog_Addr;
  logic              Start, Running, Done, Timeout;
  logic [ADDR_W-1:0] Start_Addr;
  logic [CNT_W-1:0]  InstrCount;
  logic [1:0]        State_Dbg;
  logic              Host_Req, Host_WE, Host_Gnt;
  logic [ADDR_W-1:0] Host_Addr;
  logic [DATA_W-1:0] Host_WData, Host_RData;
  logic              Core_MemRead, Core_MemWrite;
  logic [ADDR_W-1:0] Core_Addr;
  logic [DATA_W-1:0] Core_WData, Core_RData;
  logic              Mem_RE, Mem_WE;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData, Mem_RData;

  logic [DATA_W-1:0] mem [256];
  logic [31:0]       exp_q[$];
  int                checks = 0;
  int                errors = 0;

  run_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_CYCLES(8)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Go(Go), .Prog_Addr(Prog_Addr), .Halt(Halt),
    .Start(Start), .Start_Addr(Start_Addr), .Running(Running), .Done(Done),
    .Timeout(Timeout), .InstrCount(InstrCount), .State_Dbg(State_Dbg),
    .Host_Req(Host_Req), .Host_WE(Host_WE), .Host_Addr(Host_Addr),
    .Host_WData(Host_WData), .Host_Gnt(Host_Gnt), .Host_RData(Host_RData),
    .Core_MemRead(Core_MemRead), .Core_MemWrite(Core_MemWrite), .Core_Addr(Core_Addr),
    .Core_WData(Core_WData), .Core_RData(Core_RData),
    .Mem_RE(Mem_RE), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData)
  );

  // Clock and DataRAM model (registered write, combinational read).
  always #5 CLK = ~CLK;
  always @(posedge CLK) if (Mem_WE) mem[Mem_Addr] <= Mem_WData;
  assign Mem_RData = mem[Mem_Addr];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, got %0h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  // Push an expectation when the step is driven and compare it once the DUT output has settled.
  task automatic ev(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(exp);
    chk(tag, obs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0; Go = 1'b0; Halt = 1'b0; Prog_Addr = '0;
    Host_Req = 1'b1; Host_WE = 1'b1; Host_Addr = 8'h10; Host_WData = 8'h77;
    Core_MemRead = 1'b0; Core_MemWrite = 1'b0; Core_Addr = '0; Core_WData = '0;

    // Reset with a host write pending: the write must not reach memory.
    tick();
    ev("rst_state", 32'(State_Dbg), 32'(S_IDLE));
    ev("rst_start", 32'(Start), 32'd1);
    ev("rst_done", 32'(Done), 32'd0);
    ev("rst_count", 32'(InstrCount), 32'd0);
    ev("rst_mem_we", 32'(Mem_WE), 32'd0);
    ev("rst_start_addr", 32'(Start_Addr), 32'd0);

    // Host preload in IDLE, then read back.
    Reset_n = 1'b1; Host_Req = 1'b1; Host_WE = 1'b1; Host_Addr = 8'h10; Host_WData = 8'hA5;
    #1;
    ev("pre_gnt", 32'(Host_Gnt), 32'd1);
    ev("pre_mem_we", 32'(Mem_WE), 32'd1);
    tick();
    Host_WE = 1'b0;
    #1;
    ev("rd_gnt", 32'(Host_Gnt), 32'd1);
    ev("rd_mem_re", 32'(Mem_RE), 32'd1);
    ev("rd_data", 32'(Host_RData), 32'hA5);

    // Go while host holds memory: stay in IDLE.
    Go = 1'b1; Prog_Addr = 8'h20;
    tick();
    ev("hostwins_1", 32'(State_Dbg), 32'(S_IDLE));
    tick();
    ev("hostwins_2", 32'(State_Dbg), 32'(S_IDLE));
    Host_Req = 1'b0;
    tick();
    ev("launch_state", 32'(State_Dbg), 32'(S_LAUNCH));
    ev("launch_start", 32'(Start), 32'd1);
    // Host write attempt in LAUNCH stalls.
    Host_Req = 1'b1; Host_WE = 1'b1; Host_WData = 8'hFF;
    #1;
    ev("launch_gnt", 32'(Host_Gnt), 32'd0);
    ev("launch_mem_we", 32'(Mem_WE), 32'd0);
    tick();
    ev("run_start_addr", 32'(Start_Addr), 32'h20);

    // Run with Halt on the 5th RUN cycle; core write on cycle 2 while host stalls.
    for (int k = 1; k <= 5; k++) begin
      Halt = (k == 5);
      Host_Req = (k < 5);
      Core_MemWrite = (k == 2); Core_Addr = 8'h30; Core_WData = 8'h5A;
      #1;
      ev($sformatf("run%0d_start", k), 32'(Start), 32'd0);
      ev($sformatf("run%0d_running", k), 32'(Running), 32'd1);
      ev($sformatf("run%0d_count", k), 32'(InstrCount), 32'(k - 1));
      ev($sformatf("run%0d_gnt", k), 32'(Host_Gnt), 32'd0);
      if (k == 2) begin
        ev("core_mem_we", 32'(Mem_WE), 32'd1);
        ev("core_mem_addr", 32'(Mem_Addr), 32'h30);
      end
      tick();
    end
    Halt = 1'b0; Core_MemWrite = 1'b0;
    ev("halt_state", 32'(State_Dbg), 32'(S_DONE));
    ev("halt_done", 32'(Done), 32'd1);
    ev("halt_count", 32'(InstrCount), 32'd5);
    ev("halt_timeout", 32'(Timeout), 32'd0);
    ev("halt_start", 32'(Start), 32'd1);
    tick();
    ev("done_hold", 32'(State_Dbg), 32'(S_DONE));
    // Host reads in DONE: core store landed, preload untouched by stalled host write.
    Host_Req = 1'b1; Host_WE = 1'b0; Host_Addr = 8'h30;
    #1;
    ev("done_gnt", 32'(Host_Gnt), 32'd1);
    ev("done_rd30", 32'(Host_RData), 32'h5A);
    Host_Addr = 8'h10;
    #1;
    ev("done_rd10", 32'(Host_RData), 32'hA5);
    // Core write outside RUN is dropped.
    Host_Req = 1'b0; Core_MemWrite = 1'b1;
    #1;
    ev("core_outside_we", 32'(Mem_WE), 32'd0);
    Core_MemWrite = 1'b0; Go = 1'b0;
    tick();
    ev("back_idle", 32'(State_Dbg), 32'(S_IDLE));

    // Timeout run, Go dropped mid-RUN.
    Go = 1'b1; Prog_Addr = 8'h40;
    tick();
    tick();
    for (int k = 1; k <= 8; k++) begin
      Go = (k < 3);
      #1;
      ev($sformatf("to%0d_running", k), 32'(Running), 32'd1);
      ev($sformatf("to%0d_count", k), 32'(InstrCount), 32'(k - 1));
      tick();
    end
    ev("to_state", 32'(State_Dbg), 32'(S_DONE));
    ev("to_count", 32'(InstrCount), 32'd8);
    ev("to_timeout", 32'(Timeout), 32'd1);
    ev("to_start_addr", 32'(Start_Addr), 32'h40);
    tick();
    ev("to_idle", 32'(State_Dbg), 32'(S_IDLE));

    // Halt on the final allowed cycle: Halt wins, Timeout cleared.
    Go = 1'b1;
    tick();
    tick();
    for (int k = 1; k <= 8; k++) begin
      Halt = (k == 8);
      #1;
      ev($sformatf("hl%0d_count", k), 32'(InstrCount), 32'(k - 1));
      tick();
    end
    Halt = 1'b0;
    ev("hl_state", 32'(State_Dbg), 32'(S_DONE));
    ev("hl_count", 32'(InstrCount), 32'd8);
    ev("hl_timeout", 32'(Timeout), 32'd0);
    Go = 1'b0;
    tick();

    // Reset in RUN cycle 3.
    Go = 1'b1;
    tick();
    tick();
    tick();
    tick();
    ev("mid_running", 32'(Running), 32'd1);
    ev("mid_count", 32'(InstrCount), 32'd2);
    Reset_n = 1'b0;
    tick();
    ev("mrst_state", 32'(State_Dbg), 32'(S_IDLE));
    ev("mrst_start", 32'(Start), 32'd1);
    ev("mrst_count", 32'(InstrCount), 32'd0);
    ev("mrst_running", 32'(Running), 32'd0);
    Reset_n = 1'b1; Go = 1'b0;
    tick();
    ev("mrst_idle", 32'(State_Dbg), 32'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
